// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner.
// A tick divider feeds a 16-step brightness phase; each full phase sweep is one
// digit slot, and NUM_DIGITS slots make a frame. New data is loaded into a
// shadow register at any time and copied to the display register at the frame
// wrap, so a frame never shows a mix of old and new digits.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 6250
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_bin,
  input  logic [NUM_DIGITS-1:0]   i_dot,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_load,
  input  logic                    i_lzb,
  input  logic [3:0]              i_bright,
  output logic [NUM_DIGITS-1:0]   o_seg_select,
  output logic [7:0]              o_hex,
  output logic                    o_frame
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [TW-1:0]           r_tick;
  logic [3:0]              r_phase;
  logic [IW-1:0]           r_idx;

  logic [4*NUM_DIGITS-1:0] r_sh_bin,   r_dp_bin;
  logic [NUM_DIGITS-1:0]   r_sh_dot,   r_dp_dot;
  logic [NUM_DIGITS-1:0]   r_sh_blank, r_dp_blank;

  logic [NUM_DIGITS-1:0]   r_sel;
  logic [7:0]              r_hex;
  logic                    r_frame;

  logic                    w_tick_wrap;
  logic                    w_slot_end;
  logic                    w_idx_last;
  logic                    w_idx_wrap;
  logic [NUM_DIGITS-1:0]   w_lzb;
  logic [3:0]              w_nib;
  logic                    w_anode_on;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [7:0]              w_hex;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'h0: f_dec = 7'h40;
      4'h1: f_dec = 7'h79;
      4'h2: f_dec = 7'h24;
      4'h3: f_dec = 7'h30;
      4'h4: f_dec = 7'h19;
      4'h5: f_dec = 7'h12;
      4'h6: f_dec = 7'h02;
      4'h7: f_dec = 7'h78;
      4'h8: f_dec = 7'h00;
      4'h9: f_dec = 7'h10;
      4'hA: f_dec = 7'h08;
      4'hB: f_dec = 7'h03;
      4'hC: f_dec = 7'h46;
      4'hD: f_dec = 7'h21;
      4'hE: f_dec = 7'h06;
      default: f_dec = 7'h0E;
    endcase
  endfunction

  assign w_tick_wrap = (r_tick == TW'(TICK_DIV - 1));
  assign w_slot_end  = w_tick_wrap && (r_phase == 4'hF);
  assign w_idx_last  = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_idx_wrap  = w_slot_end && w_idx_last;

  // Tick / phase / digit-index counters; a slot ends when both inner counters wrap.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_tick  <= '0;
      r_phase <= '0;
      r_idx   <= '0;
    end else if (w_tick_wrap) begin
      r_tick  <= '0;
      r_phase <= r_phase + 4'd1;
      if (r_phase == 4'hF)
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  // Shadow takes every load (last wins); display takes the pre-edge shadow at the frame wrap.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sh_bin   <= '0;
      r_sh_dot   <= '0;
      r_sh_blank <= '0;
      r_dp_bin   <= '0;
      r_dp_dot   <= '0;
      r_dp_blank <= '0;
    end else begin
      if (i_load) begin
        r_sh_bin   <= i_bin;
        r_sh_dot   <= i_dot;
        r_sh_blank <= i_blank;
      end
      if (w_idx_wrap) begin
        r_dp_bin   <= r_sh_bin;
        r_dp_dot   <= r_sh_dot;
        r_dp_blank <= r_sh_blank;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero; digit 0 is exempt.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    w_lzb    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (r_dp_bin[4*i +: 4] == 4'h0);
      w_lzb[i] = i_lzb & zero_run;
    end
  end

  // Next anode / segment pattern for the digit the counters currently point at.
  always_comb begin
    w_nib      = r_dp_bin[{r_idx, 2'b00} +: 4];
    w_anode_on = !r_dp_blank[r_idx] && (r_phase <= i_bright);
    w_sel      = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_anode_on && (r_idx == IW'(i)))
        w_sel[i] = 1'b0;
    w_hex      = {~r_dp_dot[r_idx], w_lzb[r_idx] ? 7'h7F : f_dec(w_nib)};
  end

  // Output register: anode and segments update on the same edge, one cycle behind the counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sel   <= '1;
      r_hex   <= 8'hFF;
      r_frame <= 1'b0;
    end else begin
      r_sel   <= w_sel;
      r_hex   <= w_hex;
      r_frame <= w_idx_wrap;
    end
  end

  assign o_seg_select = r_sel;
  assign o_hex        = r_hex;
  assign o_frame      = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4 digits, 2 cycles per sub-phase:
// 32-cycle slots, 128-cycle frames). Expected slot contents are queued when
// stimulus is applied and popped while the frame is observed.
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int TD = 2;
  localparam int SLOT = 16 * TD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bin = '0;
  logic [3:0]  dot = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  sel;
  logic [7:0]  hex;
  logic        frame;

  seven_seg_scanner #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_bin(bin), .i_dot(dot), .i_blank(blank),
    .i_load(load), .i_lzb(lzb), .i_bright(bright),
    .o_seg_select(sel), .o_hex(hex), .o_frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] on_pat;
    logic [7:0] hex;
    bit         chk_hex;
    int         low;
  } slot_t;

  slot_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2,
                            input logic [7:0] h3, input logic [3:0] blk, input int low);
    logic [7:0] hh [4];
    hh = '{h0, h1, h2, h3};
    for (int d = 0; d < ND; d++) begin
      slot_t s;
      s.on_pat  = ~(4'b0001 << d);
      s.hex     = hh[d];
      s.chk_hex = !blk[d];
      s.low     = blk[d] ? 0 : low;
      sb.push_back(s);
    end
  endtask

  // Wait (bounded) for the frame pulse; returns at the sample showing it.
  task automatic sync_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 400);
    chk({tag, " sync"}, frame, 1);
  endtask

  // Observe one full frame that starts at the next sample.
  task automatic check_frame(input string tag);
    for (int d = 0; d < ND; d++) begin
      slot_t s;
      int on_cnt = 0, sel_err = 0, hex_err = 0, frm_err = 0;
      logic [7:0] hex0 = '0;
      logic [3:0] exp_sel;
      if (sb.size() == 0) begin
        chk({tag, " scoreboard empty"}, 1, 0);
        return;
      end
      s = sb.pop_front();
      for (int k = 0; k < SLOT; k++) begin
        @(negedge clk);
        exp_sel = (k < s.low) ? s.on_pat : 4'hF;
        if (sel === s.on_pat) on_cnt++;
        if (sel !== exp_sel) sel_err++;
        if (k == 0) hex0 = hex;
        if (s.chk_hex && hex !== s.hex) hex_err++;
        if (frame !== ((d == ND - 1) && (k == SLOT - 1))) frm_err++;
      end
      chk($sformatf("%s d%0d anode-low cycles", tag, d), on_cnt, s.low);
      chk($sformatf("%s d%0d anode pattern errs", tag, d), sel_err, 0);
      if (s.chk_hex) begin
        chk($sformatf("%s d%0d hex", tag, d), hex0, s.hex);
        chk($sformatf("%s d%0d hex errs", tag, d), hex_err, 0);
      end
      chk($sformatf("%s d%0d frame errs", tag, d), frm_err, 0);
    end
  endtask

  initial begin
    int pos, pulses;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset sel", sel, 4'hF);
    chk("reset hex", hex, 8'hFF);
    chk("reset frame", frame, 0);
    rst_n = 1'b1;

    // Basic decode at full brightness
    bin = 16'h12C0; dot = 4'b0000; blank = 4'b0000; bright = 4'hF;
    load = 1'b1; @(negedge clk); load = 1'b0;
    push_frame(8'hC0, 8'hC6, 8'hA4, 8'hF9, 4'b0000, 32);
    sync_frame("base");
    check_frame("base");

    // Brightness 3: anode low for phases 0..3 only
    bright = 4'd3;
    push_frame(8'hC0, 8'hC6, 8'hA4, 8'hF9, 4'b0000, 8);
    check_frame("bright3");

    // Leading-zero blanking with a dot on a blanked digit; two loads, last wins
    bright = 4'hF; lzb = 1'b1;
    bin = 16'hFFFF; dot = 4'b1111;
    load = 1'b1; @(negedge clk);
    bin = 16'h0005; dot = 4'b0100;
    @(negedge clk); load = 1'b0;
    push_frame(8'h92, 8'hFF, 8'h7F, 8'hFF, 4'b0000, 32);
    sync_frame("lzb");
    check_frame("lzb");

    // Per-digit blank
    lzb = 1'b0; bin = 16'h12C0; dot = 4'b0000; blank = 4'b1010;
    load = 1'b1; @(negedge clk); load = 1'b0;
    push_frame(8'hC0, 8'hC6, 8'hA4, 8'hF9, 4'b1010, 32);
    sync_frame("blank");
    check_frame("blank");

    // Load coincident with the wrap edge: old frame first, new one after
    push_frame(8'hC0, 8'hC6, 8'hA4, 8'hF9, 4'b1010, 32);
    push_frame(8'h03, 8'h88, 8'h90, 8'h80, 4'b0000, 32);
    repeat (127) @(negedge clk);
    bin = 16'h89AB; dot = 4'b0001; blank = 4'b0000;
    load = 1'b1; @(negedge clk); load = 1'b0;
    chk("coinc wrap frame", frame, 1);
    check_frame("coinc_old");
    check_frame("coinc_new");

    // One-cycle reset in the middle of digit 2
    repeat (2 * SLOT + 9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset sel", sel, 4'hF);
    chk("midreset hex", hex, 8'hFF);
    chk("midreset frame", frame, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset sel", sel, 4'hE);
    chk("post-reset hex", hex, 8'hC0);
    pos = 0; pulses = 0;
    for (int k = 1; k <= 127; k++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        pulses++;
        pos = k;
      end
    end
    chk("post-reset frame pos", pos, 127);
    chk("post-reset frame count", pulses, 1);
    // Shadow was cleared by reset, so the next frame shows all zeros
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000, 32);
    check_frame("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
